// File: rtl/awb_gain_est_if.sv
// RGB video stream bundle observed by the white-balance estimator.
// master drives the stream; slave only samples it.
interface awb_gain_est_if;
   logic       in_vsync;
   logic       in_hsync;
   logic       in_den;
   logic [7:0] in_data_R;
   logic [7:0] in_data_G;
   logic [7:0] in_data_B;

   modport master (output in_vsync, in_hsync, in_den, in_data_R, in_data_G, in_data_B);
   modport slave  (input  in_vsync, in_hsync, in_den, in_data_R, in_data_G, in_data_B);
endinterface

// File: rtl/awb_gain_est.sv
// Gray-world AWB estimator: per-frame channel sums, then gain_R = sumG/sumR and
// gain_B = sumG/sumB in Q8.8 from a shared 1-bit-per-cycle restoring divider.
module awb_gain_est #(
   parameter int unsigned source_h = 512,
   parameter int unsigned source_v = 512,
   parameter logic [7:0]  SAT_TH   = 8'd250,
   parameter logic [15:0] GAIN_MIN = 16'h0080,
   parameter logic [15:0] GAIN_MAX = 16'h0400
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          awb_en,
   awb_gain_est_if.slave vid,
   output logic [15:0]   gain_R,
   output logic [15:0]   gain_B,
   output logic          gain_valid,
   output logic          busy,
   output logic [1:0]    dbg_state
);
   // Stream semantics: in_den qualifies the pixel in the same cycle, there is no
   // backpressure; gain_valid is a one-cycle strobe marking a joint gain_R/gain_B update.
   typedef enum logic [1:0] {IDLE = 2'd0, DIV_R = 2'd1, DIV_B = 2'd2, UPDATE = 2'd3} state_e;

   localparam logic [31:0] PIX_LIMIT = 32'(source_h * source_v);

   logic       r_vsync, r_vsync_d, r_hsync, r_den, r_awb_en, vsync_rise;
   logic [7:0] r_R, r_G, r_B;
   logic       unused_hsync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vsync    <= 1'b0;
         r_vsync_d  <= 1'b0;
         r_hsync    <= 1'b0;
         r_den      <= 1'b0;
         r_awb_en   <= 1'b0;
         r_R        <= 8'd0;
         r_G        <= 8'd0;
         r_B        <= 8'd0;
         vsync_rise <= 1'b0;
      end else begin
         r_vsync    <= vid.in_vsync;
         r_vsync_d  <= r_vsync;
         r_hsync    <= vid.in_hsync;
         r_den      <= vid.in_den;
         r_awb_en   <= awb_en;
         r_R        <= vid.in_data_R;
         r_G        <= vid.in_data_G;
         r_B        <= vid.in_data_B;
         vsync_rise <= r_vsync & ~r_vsync_d;
      end
   end

   assign unused_hsync = r_hsync;

   logic [31:0] sum_R, sum_G, sum_B, pix_cnt;
   logic        pix_ok, snap;
   state_e      state, state_nx;

   // Pixel count saturates at one frame's worth so the 32-bit sums can never wrap.
   assign pix_ok = r_den && (r_R < SAT_TH) && (r_G < SAT_TH) && (r_B < SAT_TH) &&
                   (pix_cnt < PIX_LIMIT);
   assign snap   = vsync_rise && (state == IDLE) && r_awb_en && (pix_cnt != 32'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_R   <= 32'd0;
         sum_G   <= 32'd0;
         sum_B   <= 32'd0;
         pix_cnt <= 32'd0;
      end else if (vsync_rise) begin
         sum_R   <= 32'd0;
         sum_G   <= 32'd0;
         sum_B   <= 32'd0;
         pix_cnt <= 32'd0;
      end else if (pix_ok) begin
         sum_R   <= sum_R + {24'd0, r_R};
         sum_G   <= sum_G + {24'd0, r_G};
         sum_B   <= sum_B + {24'd0, r_B};
         pix_cnt <= pix_cnt + 32'd1;
      end
   end

   logic [5:0] bit_cnt;
   logic       last_bit;
   assign last_bit = (bit_cnt == 6'd39);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (snap) state_nx = DIV_R;
         DIV_R:  if (last_bit) state_nx = DIV_B;
         DIV_B:  if (last_bit) state_nx = UPDATE;
         UPDATE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // Restoring divider: the dividend shifts out of quo's MSB while quotient bits shift in.
   logic [39:0] quo, quo_nx;
   logic [31:0] rem, rem_nx, divisor;
   logic [32:0] trial, diff;
   logic        take;

   always_comb begin
      trial  = {rem, quo[39]};
      diff   = trial - {1'b0, divisor};
      take   = (trial >= {1'b0, divisor});
      rem_nx = take ? diff[31:0] : trial[31:0];
      quo_nx = {quo[38:0], take};
   end

   function automatic logic [15:0] clamp_gain(input logic [39:0] q, input logic div_zero);
      if (div_zero || (q > {24'd0, GAIN_MAX})) return GAIN_MAX;
      else if (q < {24'd0, GAIN_MIN})          return GAIN_MIN;
      else                                     return q[15:0];
   endfunction

   logic [31:0] snap_G, snap_B;
   logic [15:0] pend_R, pend_B;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         quo        <= 40'd0;
         rem        <= 32'd0;
         divisor    <= 32'd0;
         bit_cnt    <= 6'd0;
         snap_G     <= 32'd0;
         snap_B     <= 32'd0;
         pend_R     <= 16'd0;
         pend_B     <= 16'd0;
         gain_R     <= 16'h0100;
         gain_B     <= 16'h0100;
         gain_valid <= 1'b0;
      end else begin
         gain_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (snap) begin
                  quo     <= {sum_G, 8'h00};
                  rem     <= 32'd0;
                  divisor <= sum_R;
                  bit_cnt <= 6'd0;
                  snap_G  <= sum_G;
                  snap_B  <= sum_B;
               end
            end
            DIV_R: begin
               if (last_bit) begin
                  pend_R  <= clamp_gain(quo_nx, divisor == 32'd0);
                  quo     <= {snap_G, 8'h00};
                  rem     <= 32'd0;
                  divisor <= snap_B;
                  bit_cnt <= 6'd0;
               end else begin
                  quo     <= quo_nx;
                  rem     <= rem_nx;
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            DIV_B: begin
               if (last_bit) begin
                  pend_B <= clamp_gain(quo_nx, divisor == 32'd0);
               end else begin
                  quo     <= quo_nx;
                  rem     <= rem_nx;
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            UPDATE: begin
               gain_R     <= pend_R;
               gain_B     <= pend_B;
               gain_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_awb_gain_est.sv
// Self-checking bench for awb_gain_est: directed frames plus random frames
// scored against a frame-level gray-world reference model.
module tb_awb_gain_est;
   localparam logic [15:0] GMIN = 16'h0080;
   localparam logic [15:0] GMAX = 16'h0400;
   localparam int          SAT  = 250;
   localparam int          LAT  = 84;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        awb_en = 1'b0;
   logic [15:0] gain_R, gain_B;
   logic        gain_valid, busy;
   logic [1:0]  dbg_state;

   awb_gain_est_if vif ();

   awb_gain_est dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .awb_en     (awb_en),
      .vid        (vif.slave),
      .gain_R     (gain_R),
      .gain_B     (gain_B),
      .gain_valid (gain_valid),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset / cycle count
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [31:0] cur_gains = 32'h0100_0100;

   logic [7:0] fr_r[256], fr_g[256], fr_b[256];
   int         fr_w, fr_h;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- reference model
   function automatic logic [15:0] ref_gain(input longint num, input longint den);
      longint q;
      if (den == 0) return GMAX;
      q = (num * 256) / den;
      if (q > longint'(GMAX)) return GMAX;
      if (q < longint'(GMIN)) return GMIN;
      return q[15:0];
   endfunction

   function automatic bit frame_model(output logic [31:0] g);
      longint sr = 0, sg = 0, sb = 0, n = 0;
      for (int i = 0; i < fr_w * fr_h; i++) begin
         if (fr_r[i] < SAT && fr_g[i] < SAT && fr_b[i] < SAT) begin
            sr += longint'(fr_r[i]);
            sg += longint'(fr_g[i]);
            sb += longint'(fr_b[i]);
            n++;
         end
      end
      g = {ref_gain(sg, sr), ref_gain(sg, sb)};
      return n != 0;
   endfunction

   task automatic expect_frame(input int k, input bit en, output bit pushed);
      logic [31:0] g;
      bit          has_pix;
      has_pix = frame_model(g);
      pushed  = en && has_pix;
      if (pushed) begin
         exp_q.push_back(g);
         exp_cyc_q.push_back(k + LAT);
         cur_gains = g;
      end
   endtask

   // ---------------- monitor: every gain_valid must match the head of the queue
   always @(negedge clk) begin
      if (reset_n && gain_valid) begin
         check("valid_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("gains", {gain_R, gain_B}, exp_q.pop_front());
            check("valid_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick_until(input int target);
      while (cyc < target) begin @(posedge clk); #1; end
   endtask

   task automatic goto_neg(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   task automatic fill_const(input int w, input int h, input int r, input int g, input int b);
      fr_w = w; fr_h = h;
      for (int i = 0; i < w * h; i++) begin
         fr_r[i] = 8'(r); fr_g[i] = 8'(g); fr_b[i] = 8'(b);
      end
   endtask

   task automatic fill_rand();
      int rmax, gmax, bmax;
      fr_w = $urandom_range(2, 16);
      fr_h = $urandom_range(1, 6);
      rmax = $urandom_range(0, 255);
      gmax = $urandom_range(0, 255);
      bmax = $urandom_range(0, 255);
      for (int i = 0; i < fr_w * fr_h; i++) begin
         fr_r[i] = 8'($urandom_range(0, rmax));
         fr_g[i] = 8'($urandom_range(0, gmax));
         fr_b[i] = 8'($urandom_range(0, bmax));
      end
   endtask

   task automatic send_frame();
      int idx = 0;
      for (int y = 0; y < fr_h; y++) begin
         for (int x = 0; x < fr_w; x++) begin
            @(posedge clk); #1;
            vif.in_den    = 1'b1;
            vif.in_data_R = fr_r[idx];
            vif.in_data_G = fr_g[idx];
            vif.in_data_B = fr_b[idx];
            idx++;
         end
         @(posedge clk); #1;
         vif.in_den    = 1'b0;
         vif.in_hsync  = 1'b1;
         vif.in_data_R = 8'($urandom);
         vif.in_data_G = 8'($urandom);
         vif.in_data_B = 8'($urandom);
         tick(1);
         vif.in_hsync = 1'b0;
         tick(2);
      end
   endtask

   task automatic vsync(output int k);
      @(posedge clk); #1;
      vif.in_vsync = 1'b1;
      k = cyc;
      tick(2);
      vif.in_vsync = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
      check({tag, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic frame_and_check(input string tag, input bit en);
      int   k;
      bit   pushed;
      logic busy_seen;
      send_frame();
      vsync(k);
      expect_frame(k, en, pushed);
      if (pushed) drain(tag);
      else begin
         busy_seen = 1'b0;
         for (int i = 0; i < 100; i++) begin @(negedge clk); busy_seen |= busy; end
         check({tag, "_no_busy"}, 32'(busy_seen), 0);
      end
      check({tag, "_gains"}, {gain_R, gain_B}, cur_gains);
   endtask

   // ---------------- directed + random sequence
   initial begin
      int k, k2;
      bit pushed;
      vif.in_vsync = 1'b0; vif.in_hsync = 1'b0; vif.in_den = 1'b0;
      vif.in_data_R = 8'd0; vif.in_data_G = 8'd0; vif.in_data_B = 8'd0;

      tick(3);
      reset_n = 1'b1;
      tick(3);
      @(negedge clk);
      check("rst_gain_R", 32'(gain_R), 32'h0100);
      check("rst_gain_B", 32'(gain_B), 32'h0100);
      check("rst_valid", 32'(gain_valid), 0);
      check("rst_busy", 32'(busy), 0);
      awb_en = 1'b1;
      tick(4);

      // uniform grey frame with exact latency checks
      fill_const(8, 4, 100, 100, 100);
      send_frame();
      vsync(k);
      expect_frame(k, 1'b1, pushed);
      goto_neg(k + 2);  check("uni_busy_E", 32'(busy), 0);
      goto_neg(k + 3);  check("uni_busy_E1", 32'(busy), 1);
      goto_neg(k + 83); check("uni_busy_E81", 32'(busy), 1);
      check("uni_valid_E81", 32'(gain_valid), 0);
      goto_neg(k + 84); check("uni_busy_E82", 32'(busy), 0);
      check("uni_valid_E82", 32'(gain_valid), 1);
      drain("uniform");
      check("uni_gains", {gain_R, gain_B}, 32'h0100_0100);

      fill_const(8, 4, 64, 128, 32);   frame_and_check("ratio", 1'b1);
      fill_const(8, 4, 200, 50, 0);    frame_and_check("clamp_div0", 1'b1);
      fill_const(8, 4, 10, 255, 10);   frame_and_check("all_sat", 1'b1);
      fill_const(0, 4, 0, 0, 0);       frame_and_check("no_den", 1'b1);
      fill_const(6, 3, 249, 249, 249); frame_and_check("just_below_sat", 1'b1);

      // second frame boundary while the divider is busy is dropped
      fill_const(8, 4, 30, 60, 90);
      send_frame();
      vsync(k);
      expect_frame(k, 1'b1, pushed);
      fill_rand();
      fill_const(4, 2, 90, 20, 70);
      send_frame();
      tick_until(k + 39);
      vsync(k2);
      goto_neg(k2 + 3);
      check("drop_busy", 32'(busy), 1);
      drain("drop");
      check("drop_gains", {gain_R, gain_B}, 32'h0200_00AA);
      fill_rand(); frame_and_check("after_drop", 1'b1);

      // awb_en low at the boundary: no snapshot
      awb_en = 1'b0;
      fill_const(8, 4, 50, 100, 150); frame_and_check("en_off", 1'b0);
      awb_en = 1'b1;
      tick(2);

      // awb_en dropped mid-division still completes
      fill_const(8, 4, 40, 120, 200);
      send_frame();
      vsync(k);
      expect_frame(k, 1'b1, pushed);
      tick_until(k + 12);
      awb_en = 1'b0;
      drain("en_mid");
      check("en_mid_gains", {gain_R, gain_B}, 32'h0300_0099);
      awb_en = 1'b1;
      tick(2);

      // reset during division aborts it
      fill_const(8, 4, 80, 40, 20);
      send_frame();
      vsync(k);
      tick_until(k + 32);
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_gains", {gain_R, gain_B}, 32'h0100_0100);
      cur_gains = 32'h0100_0100;
      tick(3);
      reset_n = 1'b1;
      tick(100);
      check("rst_mid_hold", {gain_R, gain_B}, cur_gains);
      fill_const(8, 4, 80, 40, 20); frame_and_check("post_reset", 1'b1);

      // random frames
      for (int f = 0; f < 10; f++) begin
         fill_rand();
         frame_and_check("rand", 1'b1);
      end

      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/awb_gain_est.md
# awb_gain_est

Gray-world auto-white-balance estimator that produces the red and blue gains consumed by the colour-correction stage. It observes the same RGB video stream (vsync/hsync/den + 8-bit R/G/B) that feeds the gain stage. It accumulates per-channel sums over each frame, excluding saturated pixels. During vertical blanking it computes gain_R = ΣG/ΣR and gain_B = ΣG/ΣB in unsigned Q8.8 (0x0100 = 1.0) with a sequential divider. New gains are presented once per frame.

## Interface
Parameters:
- source_h, 512, active pixels per line (sizes pixel counter)
- source_v, 512, active lines per frame (sizes pixel counter)
- SAT_TH, 8'd250, pixel excluded if any channel >= SAT_TH
- GAIN_MIN, 16'h0080, lower clamp (0.5)
- GAIN_MAX, 16'h0400, upper clamp (4.0)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- awb_en  in  1  high: compute new gains at each frame end; low: hold current gains
- in_vsync  in  1  frame sync, active high; rising edge = frame boundary
- in_hsync  in  1  line sync (not used for accumulation; registered only)
- in_den  in  1  pixel valid
- in_data_R / in_data_G / in_data_B  in  8 each  pixel channels
- gain_R  out  16  Q8.8 red gain
- gain_B  out  16  Q8.8 blue gain
- gain_valid  out  1  one-cycle pulse when gain_R/gain_B update
- busy  out  1  high while the divider is running

## Operation
- All inputs are registered once (r_*) before use. vsync edge detection uses r_vsync against its one-cycle-delayed copy.
- Accumulation: a pixel is counted in a cycle when r_den=1 and R, G, B are all < SAT_TH. It then adds to sum_R, sum_G, sum_B (32-bit each) and pix_cnt (32-bit). Sums cannot wrap for source_h*source_v <= 2^24.
- Frame boundary (cycle E, the cycle the rising edge of r_vsync is detected):
  - If state=IDLE, awb_en=1 and pix_cnt!=0, sums are snapshotted and the FSM goes to DIV_R.
  - Otherwise no snapshot is taken; this covers the case where the divider is still busy, so that frame's data is dropped.
  - In all cases the accumulators and pix_cnt clear at E. A pixel accepted in cycle E is discarded.
- FSM states and transitions:
  - IDLE -> DIV_R on snapshot.
  - DIV_R: 40-iteration restoring divide of {snap_G,8'h00} (40-bit) by snap_R, 1 bit per cycle -> DIV_B.
  - DIV_B: same for snap_B -> UPDATE.
  - UPDATE: 1 cycle -> IDLE.
- Division rules:
  - Divisor 0 yields GAIN_MAX.
  - Quotient > GAIN_MAX yields GAIN_MAX; quotient < GAIN_MIN yields GAIN_MIN.
  - Otherwise the result is quotient[15:0] (truncated, no rounding).
- UPDATE: gain_R and gain_B load both clamped quotients together, and gain_valid=1 for exactly that one cycle. The two gains never update separately.
- awb_en low mid-division: the running computation completes and updates normally. awb_en only gates new snapshots.
- busy=1 in DIV_R, DIV_B and UPDATE.

## Timing
- Reset values: gain_R=16'h0100, gain_B=16'h0100, gain_valid=0, busy=0. FSM=IDLE, accumulators and pix_cnt=0.
- Reset asserted mid-division aborts the computation. Gains return to 0x0100 with no gain_valid pulse.
- in_vsync sampled high at edge t gives detection E at edge t+2.
- busy rises at E+1.
- gain_R/gain_B/gain_valid take new values at E+82: 40 DIV_R cycles, 40 DIV_B cycles, then UPDATE. busy falls at E+82.
- The next snapshot is possible at E+82 or later. Vertical blanking must be >= 82 clocks, or alternate frames are dropped.
- Gains are stable between gain_valid pulses. Downstream samples them on gain_valid or on frame start.

## Test plan
- Reset: release reset_n with no stimulus -> gain_R=gain_B=0x0100, gain_valid=0, busy=0.
- Uniform frame R=G=B=100, 8x4 pixels, awb_en=1, then vsync rise -> exactly one gain_valid at E+82 with gain_R=gain_B=0x0100.
- Frame R=64, G=128, B=32 -> gain_R=0x0200, gain_B=0x0400 (at GAIN_MAX, not clamped). Frame R=200, G=50, B=0 -> gain_R=0x0080 (clamped from 0x0040), gain_B=0x0400 (divide-by-zero).
- Frame where every pixel has G=255, and a frame with den never asserted -> no gain_valid; gains keep their previous values.
- Second vsync rise at E+40 (while busy) -> the first computation completes at E+82; the second frame is dropped; only one gain_valid. Repeat with awb_en=0 at the frame boundary -> no busy, no update.
- Assert reset_n low at E+30 -> busy=0 and gains=0x0100 immediately; no gain_valid. The next full frame computes normally.
